// File: rtl/alu_cmd_ctrl_if.sv
// Bus bundle between alu_cmd_ctrl and its neighbours: UART RX/TX byte paths and the ALU.
// master = command controller view, slave = environment (UART + ALU) view.
interface alu_cmd_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int FN_WIDTH   = 4
);
    logic [DATA_WIDTH-1:0]   RX_P_DATA;
    logic                    RX_D_VLD;
    logic [DATA_WIDTH-1:0]   ALU_A;
    logic [DATA_WIDTH-1:0]   ALU_B;
    logic [FN_WIDTH-1:0]     ALU_FUN;
    logic                    ALU_EN;
    logic [2*DATA_WIDTH-1:0] ALU_OUT;
    logic                    OUT_VALID;
    logic [DATA_WIDTH-1:0]   TX_P_DATA;
    logic                    TX_D_VLD;
    logic                    TX_BUSY;
    logic                    CTRL_BUSY;
    logic                    CMD_DROP;

    modport master (
        input  RX_P_DATA, RX_D_VLD, ALU_OUT, OUT_VALID, TX_BUSY,
        output ALU_A, ALU_B, ALU_FUN, ALU_EN, TX_P_DATA, TX_D_VLD, CTRL_BUSY, CMD_DROP
    );

    modport slave (
        output RX_P_DATA, RX_D_VLD, ALU_OUT, OUT_VALID, TX_BUSY,
        input  ALU_A, ALU_B, ALU_FUN, ALU_EN, TX_P_DATA, TX_D_VLD, CTRL_BUSY, CMD_DROP
    );
endinterface

// File: rtl/alu_cmd_ctrl.sv
// UART-to-ALU command controller: 3-byte frame in, one ALU_EN pulse, 2-byte result (or error byte) out.
// Optional inter-byte timeout in GET_A/GET_B enabled by defining ALU_CMD_TIMEOUT_EN.
module alu_cmd_ctrl #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    FN_WIDTH   = 4,
    parameter int                    ALU_LAT    = 1,
    parameter logic [DATA_WIDTH-1:0] ERR_CODE   = 8'hEE
`ifdef ALU_CMD_TIMEOUT_EN
  , parameter int                    TIMEOUT_CYC = 1024
`endif
) (
    input logic         CLK,
    input logic         RST,
    alu_cmd_ctrl_if.master bus
);
    localparam int LAT_W = $clog2(ALU_LAT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_GET_A, S_GET_B, S_ISSUE, S_WAIT, S_SEND_LO, S_SEND_HI, S_SEND_ERR
    } state_t;

    state_t                  state, next_state;
    logic [DATA_WIDTH-1:0]   alu_a, alu_b;
    logic [FN_WIDTH-1:0]     alu_fun;
    logic [2*DATA_WIDTH-1:0] result;
    logic [LAT_W-1:0]        lat_cnt;
    logic                    ctrl_busy, cmd_drop;
    logic                    drop, hdr_ok, sample, timeout;

    assign hdr_ok = (bus.RX_P_DATA[7:4] == 4'hA);
    // Result and OUT_VALID are looked at only in the last WAIT cycle, never as a strobe.
    assign sample = (state == S_WAIT) && (lat_cnt == LAT_W'(1));

`ifdef ALU_CMD_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC);
    logic [TO_W-1:0] to_cnt;
    logic            collecting;

    assign collecting = (state == S_GET_A) || (state == S_GET_B);
    assign timeout    = collecting && !bus.RX_D_VLD && (to_cnt == TO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge CLK) begin
        if (RST)
            to_cnt <= '0;
        else if (collecting && !bus.RX_D_VLD && !timeout)
            to_cnt <= to_cnt + 1'b1;
        else
            to_cnt <= '0;
    end
`else
    assign timeout = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments and a synchronous reset inside the clocked block.
    always_ff @(posedge CLK) begin
        if (RST)
            state <= S_IDLE;
        else
            state <= next_state;
    end

    // NOTE: every signal of this block gets a default first so no path can infer a latch.
    always_comb begin
        next_state    = state;
        drop          = 1'b0;
        bus.ALU_EN    = 1'b0;
        bus.TX_D_VLD  = 1'b0;
        bus.TX_P_DATA = '0;
        case (state)
            S_IDLE: begin
                if (bus.RX_D_VLD) begin
                    if (hdr_ok) next_state = S_GET_A;
                    else        drop       = 1'b1;
                end
            end
            S_GET_A: begin
                if (bus.RX_D_VLD) next_state = S_GET_B;
                else if (timeout) begin
                    next_state = S_IDLE;
                    drop       = 1'b1;
                end
            end
            S_GET_B: begin
                if (bus.RX_D_VLD) next_state = S_ISSUE;
                else if (timeout) begin
                    next_state = S_IDLE;
                    drop       = 1'b1;
                end
            end
            S_ISSUE: begin
                bus.ALU_EN = 1'b1;
                next_state = S_WAIT;
            end
            S_WAIT: begin
                if (sample) next_state = bus.OUT_VALID ? S_SEND_LO : S_SEND_ERR;
            end
            S_SEND_LO: begin
                bus.TX_D_VLD  = 1'b1;
                bus.TX_P_DATA = result[DATA_WIDTH-1:0];
                if (!bus.TX_BUSY) next_state = S_SEND_HI;
            end
            S_SEND_HI: begin
                bus.TX_D_VLD  = 1'b1;
                bus.TX_P_DATA = result[2*DATA_WIDTH-1:DATA_WIDTH];
                if (!bus.TX_BUSY) next_state = S_IDLE;
            end
            S_SEND_ERR: begin
                bus.TX_D_VLD  = 1'b1;
                bus.TX_P_DATA = ERR_CODE;
                if (!bus.TX_BUSY) next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
        // Bytes arriving while a command is in flight are discarded.
        if (bus.RX_D_VLD && !(state inside {S_IDLE, S_GET_A, S_GET_B}))
            drop = 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            alu_a     <= '0;
            alu_b     <= '0;
            alu_fun   <= '0;
            result    <= '0;
            lat_cnt   <= '0;
            ctrl_busy <= 1'b0;
            cmd_drop  <= 1'b0;
        end else begin
            if (state == S_IDLE && bus.RX_D_VLD && hdr_ok)
                alu_fun <= bus.RX_P_DATA[FN_WIDTH-1:0];
            if (state == S_GET_A && bus.RX_D_VLD)
                alu_a <= bus.RX_P_DATA;
            if (state == S_GET_B && bus.RX_D_VLD)
                alu_b <= bus.RX_P_DATA;
            if (state == S_ISSUE)
                lat_cnt <= LAT_W'(ALU_LAT);
            else if (state == S_WAIT)
                lat_cnt <= lat_cnt - 1'b1;
            if (sample && bus.OUT_VALID)
                result <= bus.ALU_OUT;
            ctrl_busy <= (next_state != S_IDLE);
            cmd_drop  <= drop;
        end
    end

    assign bus.ALU_A     = alu_a;
    assign bus.ALU_B     = alu_b;
    assign bus.ALU_FUN   = alu_fun;
    assign bus.CTRL_BUSY = ctrl_busy;
    assign bus.CMD_DROP  = cmd_drop;
endmodule
